// File: rtl/vga_mux_pkg.sv
// Shared constants and types for the VGA layer compositor.
// Imported by layered_objects_mux and layer_priority_encoder.
package vga_mux_pkg;
  localparam int RGB_W_DEFAULT = 8;
  localparam logic [RGB_W_DEFAULT-1:0] TRANSPARENT_COLOR = 8'hFF;
  localparam int MAX_LAYERS = 16;
  typedef logic [RGB_W_DEFAULT-1:0] rgb_t;
endpackage

// File: rtl/layer_priority_encoder.sv
// Combinational find-first-set: the lowest set index wins.
// any is high when at least one bit of vector is set.
module layer_priority_encoder
  import vga_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vector,
  output logic [IW-1:0] index,
  output logic          any
);

  always_comb begin
    index = '0;
    any   = |vector;
    for (int i = N - 1; i >= 0; i--) begin
      if (vector[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/layered_objects_mux.sv
// Two-stage priority compositor with colour key and sticky collision flags.
// Collision logic is built only when LAYERS_MUX_COLLISION_EN is defined.
module layered_objects_mux
  import vga_mux_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W      = RGB_W_DEFAULT,
  parameter logic [RGB_W-1:0] TRANSPARENT = RGB_W'(TRANSPARENT_COLOR),
  localparam int WW = $clog2(NUM_LAYERS + 1),
  localparam int IW = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       layerDrawingRequest,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]       layerEnable,
  input  logic [RGB_W-1:0]            backGroundRGB,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [WW-1:0]               winnerLayer,
  output logic [NUM_LAYERS-1:0]       collisionMask,
  output logic                        collisionPulse
);

  logic [NUM_LAYERS-1:0]            w_vis;
  logic [NUM_LAYERS-1:0]            r_vis;
  logic [NUM_LAYERS-1:0][RGB_W-1:0] r_rgb;
  logic [RGB_W-1:0]                 r_bg;
  logic [IW-1:0]                    w_idx;
  logic                             w_any;
  logic [RGB_W-1:0]                 r_out;
  logic [WW-1:0]                    r_win;

  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_vis[i] = layerDrawingRequest[i] & layerEnable[i] &
                 (layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_vis <= '0;
      r_rgb <= '0;
      r_bg  <= '0;
    end else begin
      r_vis <= w_vis;
      r_rgb <= layerRGB;
      r_bg  <= backGroundRGB;
    end
  end

  layer_priority_encoder #(
    .N  (NUM_LAYERS),
    .IW (IW)
  ) u_enc (
    .vector (r_vis),
    .index  (w_idx),
    .any    (w_any)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_out <= '0;
      r_win <= '0;
    end else if (w_any) begin
      r_out <= r_rgb[w_idx];
      r_win <= WW'(w_idx);
    end else begin
      r_out <= r_bg;
      r_win <= WW'(NUM_LAYERS);
    end
  end

  assign RGBOut      = r_out;
  assign winnerLayer = r_win;

`ifdef LAYERS_MUX_COLLISION_EN
  logic [NUM_LAYERS-1:0] w_hit;
  logic [NUM_LAYERS-1:0] w_mask_nxt;
  logic [NUM_LAYERS-1:0] r_mask;
  logic                  r_pulse;

  // Frame start clears and sets in one step so the first pixel counts.
  assign w_hit      = {r_vis[NUM_LAYERS-1:1] &
                       {(NUM_LAYERS-1){r_vis[0]}}, 1'b0};
  assign w_mask_nxt = startOfFrame ? w_hit : (r_mask | w_hit);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_mask  <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_mask  <= w_mask_nxt;
      r_pulse <= |(w_mask_nxt & ~r_mask);
    end
  end

  assign collisionMask  = r_mask;
  assign collisionPulse = r_pulse;
`else
  logic w_unused_sof;

  assign w_unused_sof   = startOfFrame;
  assign collisionMask  = '0;
  assign collisionPulse = 1'b0;
`endif

endmodule

// File: tb/tb_layered_objects_mux.sv
// Scoreboard bench for layered_objects_mux: directed scenarios plus random
// pixels, checked against a behavioural compositor model.
module tb_layered_objects_mux;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         resetN;
  logic         sof;
  logic [N-1:0] req;
  logic [31:0]  rgb;
  logic [N-1:0] en;
  logic [7:0]   bg;
  logic [7:0]   rgb_out;
  logic [2:0]   win;
  logic [N-1:0] mask;
  logic         pulse;

  typedef struct {
    logic [7:0]   rgb;
    logic [2:0]   win;
    logic [N-1:0] mask;
    logic         pulse;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // model state: the pixel now held in stage 1, and the sticky mask
  logic [N-1:0] m_vis;
  logic [7:0]   m_rgb [N];
  logic [7:0]   m_bg;
  logic [N-1:0] m_mask;

  always #5 clk = ~clk;

  layered_objects_mux #(.NUM_LAYERS(N), .RGB_W(8)) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (sof),
    .layerDrawingRequest (req),
    .layerRGB            (rgb),
    .layerEnable         (en),
    .backGroundRGB       (bg),
    .RGBOut              (rgb_out),
    .winnerLayer         (win),
    .collisionMask       (mask),
    .collisionPulse      (pulse)
  );

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endfunction

  function automatic void model_reset();
    m_vis  = '0;
    m_bg   = '0;
    m_mask = '0;
    for (int i = 0; i < N; i++) m_rgb[i] = '0;
  endfunction

  task automatic pix(input logic [N-1:0] r, input logic [31:0] c,
                     input logic [N-1:0] e, input logic [7:0] b,
                     input logic s);
    exp_t x;
    logic [N-1:0] hit;
    logic [N-1:0] nm;
    bit found;
    @(negedge clk);
    req = r; rgb = c; en = e; bg = b; sof = s;
    found = 0;
    x.rgb = m_bg;
    x.win = 3'(N);
    for (int i = 0; i < N; i++) begin
      if (!found && m_vis[i]) begin
        found = 1;
        x.rgb = m_rgb[i];
        x.win = 3'(i);
      end
    end
    hit = '0;
    for (int i = 1; i < N; i++) hit[i] = m_vis[0] && m_vis[i];
    nm = s ? hit : (m_mask | hit);
`ifdef LAYERS_MUX_COLLISION_EN
    x.mask  = nm;
    x.pulse = (nm & ~m_mask) != 0;
`else
    x.mask  = '0;
    x.pulse = 1'b0;
`endif
    m_mask = nm;
    q.push_back(x);
    for (int i = 0; i < N; i++) begin
      m_rgb[i] = c[i*8 +: 8];
      m_vis[i] = r[i] && e[i] && (c[i*8 +: 8] != 8'hFF);
    end
    m_bg = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    req = '0; rgb = '0; en = '0; bg = '0; sof = 1'b0;
    #1;
    chk("rst_rgb", 32'(rgb_out), 32'h0);
    chk("rst_win", 32'(win), 32'h0);
    chk("rst_mask", 32'(mask), 32'h0);
    chk("rst_pulse", 32'(pulse), 32'h0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    model_reset();
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("rgb", 32'(rgb_out), 32'(x.rgb));
      chk("winner", 32'(win), 32'(x.win));
      chk("mask", 32'(mask), 32'(x.mask));
      chk("pulse", 32'(pulse), 32'(x.pulse));
    end
  end

  initial begin
    resetN = 1'b0;
    req = '0; rgb = '0; en = '0; bg = '0; sof = 1'b0;
    model_reset();
    do_reset();
    // background after reset release
    repeat (3) pix(4'b0000, 32'h0, 4'hF, 8'h1C, 1'b0);
    // layers 1 and 3, then layer 1 drops
    repeat (2) pix(4'b1010, 32'h0300_E000, 4'hF, 8'h1C, 1'b0);
    repeat (2) pix(4'b1000, 32'h0300_E000, 4'hF, 8'h1C, 1'b0);
    // transparent layer 1, layer 2 visible, then layer 2 disabled
    repeat (2) pix(4'b0110, 32'h0055_FF00, 4'hF, 8'h1C, 1'b0);
    repeat (2) pix(4'b0110, 32'h0055_FF00, 4'b1011, 8'h1C, 1'b0);
    // collisions 0/2, repeat in frame, clearing frame start
    pix(4'b0000, 32'h0, 4'hF, 8'h1C, 1'b1);
    pix(4'b0101, 32'h0022_0011, 4'hF, 8'h1C, 1'b0);
    repeat (2) pix(4'b0000, 32'h0, 4'hF, 8'h1C, 1'b0);
    pix(4'b0101, 32'h0022_0011, 4'hF, 8'h1C, 1'b0);
    repeat (2) pix(4'b0000, 32'h0, 4'hF, 8'h1C, 1'b0);
    pix(4'b0000, 32'h0, 4'hF, 8'h1C, 1'b1);
    pix(4'b0000, 32'h0, 4'hF, 8'h1C, 1'b0);
    // frame start meeting a 0/3 overlap
    pix(4'b1001, 32'h3300_0011, 4'hF, 8'h1C, 1'b0);
    pix(4'b0000, 32'h0, 4'hF, 8'h1C, 1'b1);
    pix(4'b0000, 32'h0, 4'hF, 8'h1C, 1'b0);
    // build mask 0110 then reset mid-frame
    pix(4'b0000, 32'h0, 4'hF, 8'h1C, 1'b1);
    pix(4'b0011, 32'h0000_4411, 4'hF, 8'h1C, 1'b0);
    pix(4'b0101, 32'h0055_0011, 4'hF, 8'h1C, 1'b0);
    pix(4'b0000, 32'h0, 4'hF, 8'h1C, 1'b0);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] c;
      logic [N-1:0] e;
      for (int k = 0; k < N; k++)
        c[k*8 +: 8] = ($urandom % 4 == 0) ? 8'hFF : 8'($urandom);
      e = ($urandom % 6 == 0) ? N'($urandom) : 4'hF;
      if (i == 200) do_reset();
      pix(N'($urandom), c, e, 8'($urandom), ($urandom % 40) == 0);
    end
    pix(4'b0000, 32'h0, 4'hF, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
